// File: rtl/pipe_stage.sv
// Elastic pipeline stage: valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush and a saturating stall counter.
module pipe_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SKID  = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             clr_cnt_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i,
    output logic [1:0]       count_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    logic             r_live;
    logic [1:0]       r_count;
    logic [1:0]       w_count_d;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] w_head_d;
    logic [CNT_W-1:0] r_stall;
    logic [CNT_W-1:0] w_stall_d;
    logic             w_ready;
    logic             w_valid;
    logic             w_push;
    logic             w_pop;
    logic             w_stalled;
    logic             w_stall_sat;

    // Flush masks both sides so nothing moves in the squash cycle.
    assign w_valid = (r_count != 2'd0) & ~flush_i;
    assign w_push  = in_valid_i & w_ready;
    assign w_pop   = w_valid & out_ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic [WIDTH-1:0] r_skid;
            logic [WIDTH-1:0] w_skid_d;

            // Ready depends only on registered state, never on out_ready_i.
            assign w_ready = r_live & (r_count != 2'd2) & ~flush_i;

            always_comb begin
                w_count_d = r_count;
                w_head_d  = r_head;
                w_skid_d  = r_skid;
                if (flush_i) begin
                    w_count_d = 2'd0;
                end else begin
                    case (r_count)
                        2'd0: begin
                            if (w_push) begin
                                w_head_d  = in_data_i;
                                w_count_d = 2'd1;
                            end
                        end
                        2'd1: begin
                            if (w_push && w_pop) begin
                                w_head_d = in_data_i;
                            end else if (w_push) begin
                                w_skid_d  = in_data_i;
                                w_count_d = 2'd2;
                            end else if (w_pop) begin
                                w_count_d = 2'd0;
                            end
                        end
                        2'd2: begin
                            if (w_pop) begin
                                w_head_d  = r_skid;
                                w_count_d = 2'd1;
                            end
                        end
                        default: begin
                            w_count_d = 2'd0;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    r_skid <= '0;
                end else begin
                    r_skid <= w_skid_d;
                end
            end
        end else begin : g_noskid
            // A full head can still accept when it is being drained this cycle.
            assign w_ready = r_live & ((r_count == 2'd0) | out_ready_i) & ~flush_i;

            always_comb begin
                w_count_d = r_count;
                w_head_d  = r_head;
                if (flush_i) begin
                    w_count_d = 2'd0;
                end else if (w_push) begin
                    w_head_d  = in_data_i;
                    w_count_d = 2'd1;
                end else if (w_pop) begin
                    w_count_d = 2'd0;
                end
            end
        end
    endgenerate

    assign w_stalled   = w_valid & ~out_ready_i;
    assign w_stall_sat = (r_stall == {CNT_W{1'b1}});

    always_comb begin
        w_stall_d = r_stall;
        if (clr_cnt_i) begin
            w_stall_d = '0;
        end else if (w_stalled && !w_stall_sat) begin
            w_stall_d = r_stall + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_stall <= '0;
        end else begin
            r_count <= w_count_d;
            r_head  <= w_head_d;
            r_stall <= w_stall_d;
        end
    end

    assign in_ready_o  = w_ready;
    assign out_valid_o = w_valid;
    assign out_data_o  = r_head;
    assign count_o     = r_count;
    assign stall_cnt_o = r_stall;

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised elastic pipeline stage that replaces the fixed-timing IF_ID/ID_EX/EX_MEM/MEM_WB latches in the pipelined CPU. It carries a WIDTH-bit payload under a valid/ready handshake and adds stall (backpressure), synchronous flush and an on-stage stall counter. The plain latches provide none of these. One instance sits between each pair of CPU stages. The hazard unit drives `flush_i` for branch/jump squash.

## Interface
- `WIDTH`, 32: payload width in bits (≥1).
- `SKID`, 1: 1 = 2-entry skid buffer with registered `in_ready_o`; 0 = 1-entry register with combinational ready pass-through.
- `CNT_W`, 16: stall counter width (≥1).
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_i`  in  1  reset; asynchronous, active-low.
- `flush_i`  in  1  synchronous squash of all held entries.
- `clr_cnt_i`  in  1  synchronous clear of `stall_cnt_o`.
- `in_valid_i`  in  1  upstream payload valid.
- `in_data_i`  in  WIDTH  upstream payload.
- `in_ready_o`  out  1  stage can accept this cycle.
- `out_valid_o`  out  1  head entry valid.
- `out_data_o`  out  WIDTH  head entry payload.
- `out_ready_i`  in  1  downstream accepts this cycle.
- `count_o`  out  2  entries held (0..2; max 1 when SKID=0).
- `stall_cnt_o`  out  CNT_W  saturating count of stalled cycles.

## Operation
- push = `in_valid_i & in_ready_o`; pop = `out_valid_o & out_ready_i`.
- Strict FIFO order. No payload is dropped or duplicated except by flush.
- The `live` flop resets to 0 and is set at the first rising edge after `rst_i` deasserts. `in_ready_o` is gated by `live`.
- SKID=1: `in_ready_o = live & (count != 2) & !flush_i`. There is no combinational path from `out_ready_i`.
  - count 0: a push moves the payload to head.
  - count 1: push+pop moves the new payload to head and count stays 1. Push only moves it to the skid entry.
  - count 2: a pop moves skid to head.
- SKID=0: `in_ready_o = live & (count == 0 | out_ready_i) & !flush_i`. Push+pop at count 1 replaces head, giving full throughput.
- `out_valid_o = (count != 0) & !flush_i`. `out_data_o` is the head register, and it holds its value when not popped.
- Flush:
  - Cycle with `flush_i=1`: `in_ready_o=0` and `out_valid_o=0`, so neither a push nor a pop occurs.
  - Next edge: count returns to 0.
  - Data registers are not cleared.
- Stall counter:
  - Increments when `out_valid_o & !out_ready_i`.
  - Saturates at 2^CNT_W−1; no wrap.
  - `clr_cnt_i` has priority over an increment, and the counter reads 0 next cycle.
  - Flush does not clear it.
- Reset while mid-transfer (any count): all entries are lost immediately, asynchronously.

## Timing
- Reset values while `rst_i`=0:
  - `in_ready_o`=0, `out_valid_o`=0, `out_data_o`=0, `count_o`=0, `stall_cnt_o`=0.
  - Internal: `live`=0, skid data=0.
- First push is possible in the cycle after the first rising edge following deassertion.
- Latency: a push at edge N makes `out_valid_o`/`out_data_o` valid after edge N, for consumption at edge N+1 at the earliest. Minimum latency is 1 cycle in both modes.
- Throughput: 1 transfer/cycle sustained in both modes.
- SKID=1 absorbs exactly one extra beat after `out_ready_i` falls.
- `count_o` and `stall_cnt_o` update at the edge; they are registered outputs.
- `flush_i` and `clr_cnt_i` act at the edge where they are sampled high; their effect is visible the following cycle.

## Test plan
- Reset/startup, SKID=1, WIDTH=32:
  - Hold `rst_i`=0 for 3 cycles with `in_valid_i`=1 → all outputs 0.
  - Release → `in_ready_o`=1 one edge later.
  - Push 0xDEADBEEF → `out_valid_o`=1 and `out_data_o`=0xDEADBEEF next cycle, `count_o`=1.
- Streaming, both modes:
  - Push 0..99 back-to-back with `out_ready_i`=1 → 100 pops in order, no bubbles after the first, `count_o`≤1.
- Backpressure, SKID=1:
  - Drop `out_ready_i` during a stream → exactly one more beat accepted, then `count_o`=2 and `in_ready_o`=0.
  - Hold 5 cycles → `stall_cnt_o`=5.
  - Release → both entries drain in order.
- Backpressure, SKID=0:
  - With `out_ready_i`=0 at count 1 → `in_ready_o`=0.
  - Raise `out_ready_i` with a push in the same cycle → head replaced, count stays 1.
- Flush:
  - At count 2, assert `flush_i` with `in_valid_i`=1 → no push and no pop that cycle, `count_o`=0 next, the in-flight payload never appears.
  - `stall_cnt_o` keeps its value.
- Counter edge, CNT_W=2:
  - Stall 6 cycles → `stall_cnt_o` saturates at 3.
  - `clr_cnt_i` during a stall → 0 next cycle, then resumes counting.
  - Assert `rst_i` low mid-stream → outputs zero asynchronously, before the next edge.
